// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    // Clear-sequencer states: SWEEP zeroes one entry per cycle, RUN serves writes.
    typedef enum logic {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } state_t;

    // Address width needed for n_regs entries (never less than one bit).
    function automatic int addr_width(input int n_regs);
        return (n_regs > 1) ? $clog2(n_regs) : 1;
    endfunction

    // LSB of field 'port' inside a packed port vector of 'width'-bit fields.
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: walks every register index once after reset or clear,
// then holds in RUN and reports ready.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    localparam int AW       = addr_width(NUM_REGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    output logic          ready,
    output logic          sweep_we,
    output logic [AW-1:0] sweep_addr
);

    // idx is one bit wider than an address so it never wraps inside a sweep.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NUM_REGS - 1);
    localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);

    state_t      state;
    state_t      state_nxt;
    logic [AW:0] idx;
    logic [AW:0] idx_nxt;

    // State and sweep index register; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
        if (!rst) begin
            state <= SWEEP;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: sweep to the last index, then RUN until clear arrives.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_nxt = state;
        idx_nxt   = idx;
        sweep_we  = 1'b0;
        ready     = 1'b0;
        case (state)
            SWEEP: begin
                sweep_we = 1'b1;
                idx_nxt  = idx + IDX_ONE;
                if (idx == LAST_IDX) begin
                    state_nxt = RUN;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                ready = 1'b1;
                if (clear) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            default: begin
                state_nxt = SWEEP;
                idx_nxt   = '0;
            end
        endcase
    end

    assign sweep_addr = idx[AW-1:0];

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port integer register file with optional write-to-read
// bypass, hard-wired zero register and a clear sweep gated by ready.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter  int NUM_REGS = 32,
    parameter  int XLEN     = 32,
    parameter  int N_READ   = 2,
    parameter  int N_WRITE  = 1,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = addr_width(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [N_READ*AW-1:0]     rd_addr,
    output logic [N_READ*XLEN-1:0]   rd_data,
    input  logic [N_WRITE-1:0]       wr_en,
    input  logic [N_WRITE*AW-1:0]    wr_addr,
    input  logic [N_WRITE*XLEN-1:0]  wr_data,
    output logic                     ready
);

    logic [XLEN-1:0]    mem [NUM_REGS];
    logic               sweep_we;
    logic [AW-1:0]      sweep_addr;
    logic [N_WRITE-1:0] port_we;
    logic [N_WRITE-1:0] port_win;

    regfile_clear_seq #(
        .NUM_REGS (NUM_REGS)
    ) u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .ready      (ready),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr)
    );

    // Writes land only in RUN, never in the clear cycle, never on a hard-wired x0.
    for (genvar w = 0; w < N_WRITE; w++) begin : g_port_we
        assign port_we[w] = wr_en[w] && ready && !clear &&
                            !((ZERO_REG != 0) && (wr_addr[port_lsb(w, AW) +: AW] == '0));
    end

    // Write-port priority: a port loses when any higher-indexed port hits the same address.
    always_comb begin
        port_win = port_we;
        for (int w = 0; w < N_WRITE; w++) begin
            for (int h = w + 1; h < N_WRITE; h++) begin
                if (port_we[h] && (wr_addr[h*AW +: AW] == wr_addr[w*AW +: AW])) begin
                    port_win[w] = 1'b0;
                end
            end
        end
    end

    // Storage update: sweep zeroing or winning write ports; reset blocks everything.
    always_ff @(posedge clk) begin
        // NOTE: the array itself has no reset; the sweep zeroes it one entry per cycle
        // while reads are forced to zero, so it can map to reset-less storage.
        if (rst) begin
            if (sweep_we) begin
                mem[sweep_addr] <= '0;
            end
            for (int w = 0; w < N_WRITE; w++) begin
                if (port_win[w]) begin
                    mem[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar r = 0; r < N_READ; r++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = rd_addr[port_lsb(r, AW) +: AW];

        // Read mux: lowest priority first, later assignments override.
        always_comb begin
            val = mem[addr];
            if (BYPASS != 0) begin
                for (int w = 0; w < N_WRITE; w++) begin
                    if (wr_en[w] && (wr_addr[w*AW +: AW] == addr)) begin
                        val = wr_data[w*XLEN +: XLEN];
                    end
                end
            end
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end
            if (!ready) begin
                val = '0;
            end
        end

        assign rd_data[port_lsb(r, XLEN) +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench: two instances share stimulus. dut_a is dual-write with
// bypass, dut_b is single-write without bypass. Expected read data per cycle
// comes from an array-based model and is checked by a negedge monitor.
module tb_regfile_multiport;

    localparam int NR  = 32;
    localparam int XL  = 32;
    localparam int AW  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic [2*AW-1:0]   rd_addr;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XL-1:0]   wr_data;
    logic [2*XL-1:0]   rd_data_a;
    logic [2*XL-1:0]   rd_data_b;
    logic              ready_a;
    logic              ready_b;

    always #5 clk = ~clk;

    regfile_multiport #(
        .NUM_REGS (NR), .XLEN (XL), .N_READ (2), .N_WRITE (2), .BYPASS (1), .ZERO_REG (1)
    ) dut_a (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .rd_addr (rd_addr),
        .rd_data (rd_data_a),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ready   (ready_a)
    );

    regfile_multiport #(
        .NUM_REGS (NR), .XLEN (XL), .N_READ (2), .N_WRITE (1), .BYPASS (0), .ZERO_REG (1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .rd_addr (rd_addr),
        .rd_data (rd_data_b),
        .wr_en   (wr_en[0]),
        .wr_addr (wr_addr[AW-1:0]),
        .wr_data (wr_data[XL-1:0]),
        .ready   (ready_b)
    );

    typedef struct {
        logic          rdy;
        logic [XL-1:0] a0, a1, b0, b1;
        logic [AW-1:0] ra0, ra1;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;

    // Reference model: register contents plus cycles left before the file is usable.
    logic [XL-1:0] mem_a [NR];
    logic [XL-1:0] mem_b [NR];
    int            sweep_left  = NR;
    bit            model_valid = 1'b0;

    logic [XL-1:0] snap_a0, snap_a1, snap_b0, snap_b1;
    logic          snap_rdy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [XL-1:0] exp_read(input bit is_a, input logic [AW-1:0] a);
        if (sweep_left != 0) return '0;
        if (a == '0) return '0;
        if (is_a) begin
            if (wr_en[1] && wr_addr[2*AW-1:AW] == a) return wr_data[2*XL-1:XL];
            if (wr_en[0] && wr_addr[AW-1:0] == a) return wr_data[XL-1:0];
            return mem_a[a];
        end
        return mem_b[a];
    endfunction

    function automatic void zero_mems();
        for (int i = 0; i < NR; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
    endfunction

    // Effect of one rising edge given the inputs currently applied.
    function automatic void model_edge();
        if (!rst) begin
            model_valid = 1'b1;
            sweep_left  = NR;
            zero_mems();
        end else if (!model_valid) begin
            sweep_left = NR;
        end else if (sweep_left > 0) begin
            sweep_left--;
        end else if (clear) begin
            sweep_left = NR;
            zero_mems();
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != '0)
                    mem_a[wr_addr[p*AW +: AW]] = wr_data[p*XL +: XL];
            end
            if (wr_en[0] && wr_addr[AW-1:0] != '0)
                mem_b[wr_addr[AW-1:0]] = wr_data[XL-1:0];
        end
    endfunction

    // One clock cycle: drive, queue expectations, snapshot, advance model at the edge.
    task automatic cycle(input logic r, input logic c, input logic [1:0] we,
                         input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                         input logic [XL-1:0] wd0, input logic [XL-1:0] wd1,
                         input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        exp_t e;
        rst     = r;
        clear   = c;
        wr_en   = we;
        wr_addr = {wa1, wa0};
        wr_data = {wd1, wd0};
        rd_addr = {ra1, ra0};
        if (model_valid) begin
            e.rdy = (sweep_left == 0);
            e.a0  = exp_read(1'b1, ra0);
            e.a1  = exp_read(1'b1, ra1);
            e.b0  = exp_read(1'b0, ra0);
            e.b1  = exp_read(1'b0, ra1);
            e.ra0 = ra0;
            e.ra1 = ra1;
            sb.push_back(e);
        end
        #2;
        snap_a0  = rd_data_a[XL-1:0];
        snap_a1  = rd_data_a[2*XL-1:XL];
        snap_b0  = rd_data_b[XL-1:0];
        snap_b1  = rd_data_b[2*XL-1:XL];
        snap_rdy = ready_a;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        cycle(1'b1, 1'b0, 2'b00, '0, '0, '0, '0, ra0, ra1);
    endtask

    // Counts cycles with ready low until it rises, bounded.
    task automatic count_sweep(input string name);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            idle('0, '0);
            if (snap_rdy === 1'b1) break;
            n++;
        end
        check(name, n, 32);
    endtask

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("ready_a", {31'd0, ready_a}, {31'd0, e.rdy});
            check("ready_b", {31'd0, ready_b}, {31'd0, e.rdy});
            check($sformatf("a_rd0[x%0d]", e.ra0), rd_data_a[XL-1:0], e.a0);
            check($sformatf("a_rd1[x%0d]", e.ra1), rd_data_a[2*XL-1:XL], e.a1);
            check($sformatf("b_rd0[x%0d]", e.ra0), rd_data_b[XL-1:0], e.b0);
            check($sformatf("b_rd1[x%0d]", e.ra1), rd_data_b[2*XL-1:XL], e.b1);
        end
    end

    initial begin
        rst = 1'b0; clear = 1'b0; wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        @(posedge clk);
        model_edge();
        #1;

        // Reset held for 3 cycles, then sweep length.
        repeat (3) cycle(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0);
        count_sweep("reset_sweep_len");
        for (int i = 0; i < NR; i += 2) idle(AW'(i), AW'(i + 1));

        // Write and read back without bypass (dut_b), x0 stays zero.
        cycle(1'b1, 1'b0, 2'b01, 5'd5, '0, 32'hDEADBEEF, '0, 5'd5, 5'd5);
        check("nobyp_same_cycle", snap_b0, 32'h0);
        idle(5'd5, 5'd0);
        check("nobyp_next_cycle", snap_b0, 32'hDEADBEEF);
        cycle(1'b1, 1'b0, 2'b01, 5'd0, '0, 32'h12345678, '0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        check("x0_stays_zero", snap_b0, 32'h0);

        // Same-cycle bypass on read port 1 (dut_a).
        cycle(1'b1, 1'b0, 2'b01, 5'd7, '0, 32'hCAFEF00D, '0, 5'd0, 5'd7);
        check("bypass_port1", snap_a1, 32'hCAFEF00D);

        // Two ports writing x9: port 1 wins in storage and bypass.
        cycle(1'b1, 1'b0, 2'b11, 5'd9, 5'd9, 32'h1111, 32'h2222, 5'd9, 5'd0);
        check("conflict_bypass", snap_a0, 32'h2222);
        idle(5'd9, 5'd9);
        check("conflict_stored", snap_a0, 32'h2222);

        // Fill x1..x31 with their index, then clear with a simultaneous write.
        for (int i = 1; i < NR; i++)
            cycle(1'b1, 1'b0, 2'b01, AW'(i), '0, XL'(i), '0, AW'(i), 5'd3);
        idle(5'd31, 5'd3);
        check("fill_x31", snap_b0, 32'd31);
        cycle(1'b1, 1'b1, 2'b01, 5'd3, '0, 32'hAAAA, '0, 5'd3, 5'd3);
        count_sweep("clear_sweep_len");
        idle(5'd3, 5'd3);
        check("x3_not_aaaa", {31'd0, snap_b0 == 32'hAAAA}, 32'd0);
        for (int i = 0; i < NR; i += 2) idle(AW'(i), AW'(i + 1));

        // Reset when the sweep index reaches 10, one cycle, then release.
        cycle(1'b0, 1'b0, 2'b00, '0, '0, '0, '0, '0, '0);
        repeat (10) idle(5'd1, 5'd2);
        cycle(1'b0, 1'b0, 2'b11, 5'd4, 5'd5, 32'h5, 32'h6, 5'd4, 5'd5);
        count_sweep("midsweep_restart_len");

        // Randomised traffic with occasional clear and reset.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] wa0, wa1, ra0, ra1;
            logic [1:0]    we;
            logic          r, c;
            wa0 = AW'($urandom_range(0, NR - 1));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : AW'($urandom_range(0, NR - 1));
            ra0 = ($urandom_range(0, 1) == 0) ? wa0 : AW'($urandom_range(0, NR - 1));
            ra1 = ($urandom_range(0, 1) == 0) ? wa1 : AW'($urandom_range(0, NR - 1));
            we  = 2'($urandom_range(0, 3));
            c   = ($urandom_range(0, 79) == 0);
            r   = ($urandom_range(0, 249) != 0);
            cycle(r, c, we, wa0, wa1, $urandom, $urandom, ra0, ra1);
        end
        idle('0, '0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
